sif_wr_arbiter: RTL

Round-robin arbiter sharing the single SIF write channel (`wa_addr`, `wa_data_wr`, `wa_wr_s`) between `NUM_REQ` write requesters. Each requester gets a bounded-burst tenure. The arbiter guarantees at least one idle cycle with `wa_wr_s` low between tenures, so the SIF write monitor sees clean ownership boundaries. It sits between the requester masters and the SIF write modport.

---
 rtl/sif_wr_arb_if.sv | 49 ++++
 rtl/sif_wr_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sif_wr_arb_if.sv
// Requester/SIF write-channel bundle shared by sif_wr_arbiter and its environment.
// The lock vector exists only when SIF_WR_ARB_LOCK_EN is defined.
interface sif_wr_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [ADDR_W-1:0]         wa_addr;
  logic [DATA_W-1:0]         wa_data_wr;
  logic                      wa_wr_s;
  logic                      wa_ready;
  logic                      busy;
  logic [ID_W-1:0]           owner_id;
`ifdef SIF_WR_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        lock;

  // Arbiter side
  modport slave (
    input  req, req_addr, req_data, wa_ready, lock,
    output gnt, ack, wa_addr, wa_data_wr, wa_wr_s, busy, owner_id
  );

  // Requesters plus SIF write port side
  modport master (
    output req, req_addr, req_data, wa_ready, lock,
    input  gnt, ack, wa_addr, wa_data_wr, wa_wr_s, busy, owner_id
  );
`else
  // Arbiter side
  modport slave (
    input  req, req_addr, req_data, wa_ready,
    output gnt, ack, wa_addr, wa_data_wr, wa_wr_s, busy, owner_id
  );

  // Requesters plus SIF write port side
  modport master (
    output req, req_addr, req_data, wa_ready,
    input  gnt, ack, wa_addr, wa_data_wr, wa_wr_s, busy, owner_id
  );
`endif

endinterface

// File: rtl/sif_wr_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters bounded-burst tenures on one SIF write channel.
// Optional SIF_WR_ARB_LOCK_EN lets the owner hold its tenure past MAX_BURST via lock.
module sif_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sif_wr_arb_if.slave sif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;

  logic [ID_W-1:0]    winner;
  logic               winner_vld;
  logic [ID_W-1:0]    idx;
  logic               own_req;
  logic               own_lock;
  logic               xfer;

  // First requester strictly after last, wrapping modulo NUM_REQ
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    idx        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last_q) + k) % NUM_REQ);
      if (!winner_vld && sif.req[idx]) begin
        winner     = idx;
        winner_vld = 1'b1;
      end
    end
  end

  assign own_req = sif.req[owner_q];
`ifdef SIF_WR_ARB_LOCK_EN
  assign own_lock = sif.lock[owner_q];
`else
  assign own_lock = 1'b0;
`endif
  assign xfer = (state_q == OWN) && own_req && sif.wa_ready;

  // Owner datapath: only req[owner] and wa_ready reach the channel combinationally
  always_comb begin
    sif.wa_wr_s    = 1'b0;
    sif.wa_addr    = '0;
    sif.wa_data_wr = '0;
    sif.ack        = '0;
    if (state_q == OWN) begin
      sif.wa_wr_s          = own_req;
      sif.wa_addr          = sif.req_addr[32'(owner_q)*ADDR_W +: ADDR_W];
      sif.wa_data_wr       = sif.req_data[32'(owner_q)*DATA_W +: DATA_W];
      sif.ack[owner_q]     = sif.wa_ready;
    end
  end

  // Next-state: grant from IDLE, release on owner drop or burst limit
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (winner_vld) begin
          state_d     = OWN;
          owner_d     = winner;
          gnt_d       = NUM_REQ'(1) << winner;
          burst_cnt_d = '0;
          busy_d      = 1'b1;
        end
      end
      OWN: begin
        if (!own_req || (xfer && (burst_cnt_q == CNT_LAST) && !own_lock)) begin
          state_d     = IDLE;
          last_d      = owner_q;
          owner_d     = '0;
          gnt_d       = '0;
          burst_cnt_d = '0;
          busy_d      = 1'b0;
        end else if (xfer && (burst_cnt_q != CNT_SAT)) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; last resets to NUM_REQ-1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
    end
  end

  assign sif.gnt      = gnt_q;
  assign sif.busy     = busy_q;
  assign sif.owner_id = owner_q;

endmodule
